pmem_burst_adapter: RTL
=======================

// Module: pmem_burst_adapter
// PURPOSE
//  Physical-memory responder for the L2 cache's line interface (pmem_read/pmem_write/pmem_address/pmem_wdata ->
//  pmem_rdata/pmem_resp). Splits each 256-bit line transfer into BEATS beats on a narrow burst memory port.
//  Sits between the L2 cache and the burst main-memory controller.
// PARAMETERS
//  LINE_WIDTH  256  cache line width, bits
//  BEAT_WIDTH  64   memory-side beat width, bits; LINE_WIDTH = BEATS*BEAT_WIDTH
//  BEATS       4    beats per line
//  ADDR_WIDTH  32   byte address width
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           synchronous active-low reset
//  pmem_read      in   1           L2 line read request, held until pmem_resp
//  pmem_write     in   1           L2 line write (writeback) request, held until pmem_resp
//  pmem_address   in   ADDR_WIDTH  line address; bits [4:0] ignored
//  pmem_wdata     in   LINE_WIDTH  writeback line
//  pmem_rdata     out  LINE_WIDTH  assembled fill line, valid with pmem_resp
//  pmem_resp      out  1           one-cycle completion pulse to L2
//  mem_read       out  1           burst read request, held for whole burst
//  mem_write      out  1           burst write request, held for whole burst
//  mem_address    out  ADDR_WIDTH  line base address, [4:0]=0, constant during burst
//  mem_wdata      out  BEAT_WIDTH  current write beat
//  mem_rdata      in   BEAT_WIDTH  current read beat, valid with mem_resp
//  mem_resp       in   1           per-beat acknowledge
// BEHAVIOUR
//  Reset (clk edge, rst_n=0): state=IDLE, beat count=0, pmem_resp=0, mem_read=0, mem_write=0,
//   mem_address=0, mem_wdata=0, pmem_rdata=0. Reset mid-burst abandons burst, no pmem_resp issued.
//  FSM: IDLE -> WR_BURST (pmem_write) | RD_BURST (pmem_read, no pmem_write) ; WR/RD_BURST -> RESP after beat
//   BEATS-1 acked ; RESP -> IDLE (pmem_resp=1 for exactly this cycle).
//  pmem_read and pmem_write together: illegal from L2; write wins (writeback precedes fill).
//  IDLE: latch {pmem_address[31:5],5'b0} and pmem_wdata into internal registers; outputs driven from those,
//   so L2 input changes mid-burst have no effect.
//  Beat k carries line bits [k*BEAT_WIDTH +: BEAT_WIDTH] (beat 0 = least significant).
//  Write: mem_wdata = beat[cnt]; cnt advances on mem_resp; mem_write drops on entering RESP.
//  Read: mem_rdata stored into beat[cnt] on mem_resp; cnt advances; mem_read drops on entering RESP.
//  mem_resp while IDLE/RESP: ignored. mem_resp may stall arbitrarily; no timeout.
//  Latency: min BEATS+2 cycles from request sampled in IDLE to pmem_resp (1 per beat with mem_resp tied high).
//  cnt wraps to 0 on entering RESP; width $clog2(BEATS).
//  pmem_rdata holds last filled line until next read completes; unchanged by writes.
//  RESP->IDLE: request still high in IDLE the cycle after pmem_resp starts a new transfer (L2 must drop it).
// CONFIGURATION
//  PMEM_BURST_ADAPTER_PERF_EN defined: adds outputs perf_reads, perf_writes (out, 32 each): count completed
//   transfers, +1 in RESP cycle, reset to 0, wrap at 2^32. Undefined: ports and counters absent; behaviour
//   otherwise identical.
// STRUCTURE
//  Package pmem_burst_pkg: state enum {IDLE, RD_BURST, WR_BURST, RESP}, default LINE/BEAT/BEATS constants.
//  Sub-module line_beat_buffer: LINE_WIDTH register with per-beat load (read assembly) and beat select mux
//   (write serialisation), indexed by cnt. FSM and counter in top.
// TESTING
//  Read 0x0000_1234, mem_resp high, beats 0x11..11,0x22..22,0x33..33,0x44..44 -> mem_address=0x0000_1220,
//   pmem_rdata={0x44..,0x33..,0x22..,0x11..}, pmem_resp single cycle at request+6.
//  Write 0x8000_0040, pmem_wdata=beats{D3,D2,D1,D0} -> mem_wdata D0,D1,D2,D3 in order, mem_write 4 cycles, pmem_resp 1 cycle.
//  mem_resp stalled 3 cycles before each beat -> data order unchanged, mem_read held throughout, resp at +18.
//  pmem_read & pmem_write together -> write burst performed, no read issued.
//  rst_n low during beat 2 of read -> next cycle all outputs 0, state IDLE, no pmem_resp; new read completes cleanly.
//  PERF_EN: 3 reads + 2 writes -> perf_reads=3, perf_writes=2; without macro the bench compiles without those ports.

Source files
------------

// File: rtl/pmem_burst_pkg.sv
// Shared types and default geometry for the pmem burst adapter.
// Line = BEATS beats of BEAT_WIDTH bits; line addresses are 32-byte aligned.
package pmem_burst_pkg;

   localparam int LINE_WIDTH_DEF = 256;
   localparam int BEAT_WIDTH_DEF = 64;
   localparam int BEATS_DEF      = 4;
   localparam int ADDR_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      RESP     = 2'd3
   } state_t;

   // Beat counter width, kept at least one bit wide for single-beat builds
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/pmem_burst_adapter_line_beat_buffer.sv
// line_beat_buffer: line-wide storage split into beats.
// Whole-line load captures the writeback line; single-beat load assembles a
// fill line. beat_out serialises the stored line by beat_sel; line_merged is
// the stored line with the beat at beat_sel replaced by beat_in, so the final
// fill beat can be folded in on the same edge it is acknowledged.
module line_beat_buffer
   import pmem_burst_pkg::*;
#(
   parameter int LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int BEAT_WIDTH = BEAT_WIDTH_DEF,
   parameter int BEATS      = BEATS_DEF,
   parameter int CNT_WIDTH  = cnt_width(BEATS_DEF)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  line_load,
   input  logic [LINE_WIDTH-1:0] line_in,
   input  logic                  beat_load,
   input  logic [CNT_WIDTH-1:0]  beat_sel,
   input  logic [BEAT_WIDTH-1:0] beat_in,
   output logic [BEAT_WIDTH-1:0] beat_out,
   output logic [LINE_WIDTH-1:0] line_merged
);

   logic [BEATS-1:0][BEAT_WIDTH-1:0] beat_q;

   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_beat
         logic [BEAT_WIDTH-1:0] beat_reg;
         logic                  hit;

         assign hit = (beat_sel == CNT_WIDTH'(gi));

         // Per-beat storage: full-line capture has priority over beat capture
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               beat_reg <= '0;
            end else if (line_load) begin
               beat_reg <= line_in[gi*BEAT_WIDTH +: BEAT_WIDTH];
            end else if (beat_load && hit) begin
               beat_reg <= beat_in;
            end
         end

         assign beat_q[gi] = beat_reg;
         assign line_merged[gi*BEAT_WIDTH +: BEAT_WIDTH] = hit ? beat_in : beat_reg;
      end
   endgenerate

   assign beat_out = beat_q[beat_sel];

endmodule

// File: rtl/pmem_burst_adapter.sv
// pmem_burst_adapter: serves L2 line reads/writebacks as BEATS-beat bursts on
// a narrow memory port. Request, address and writeback data are captured in
// IDLE, so L2 input changes during a burst are ignored. Write wins when both
// requests are raised. Optional macro PMEM_BURST_ADAPTER_PERF_EN adds
// completed-transfer counters perf_reads / perf_writes.
module pmem_burst_adapter
   import pmem_burst_pkg::*;
#(
   parameter int LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int BEAT_WIDTH = BEAT_WIDTH_DEF,
   parameter int BEATS      = BEATS_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pmem_read,
   input  logic                  pmem_write,
   input  logic [ADDR_WIDTH-1:0] pmem_address,
   input  logic [LINE_WIDTH-1:0] pmem_wdata,
   output logic [LINE_WIDTH-1:0] pmem_rdata,
   output logic                  pmem_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [BEAT_WIDTH-1:0] mem_wdata,
   input  logic [BEAT_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
`ifdef PMEM_BURST_ADAPTER_PERF_EN
   ,
   output logic [31:0]           perf_reads,
   output logic [31:0]           perf_writes
`endif
);

   localparam int CNT_WIDTH   = cnt_width(BEATS);
   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

   state_t                  state_reg;
   logic [CNT_WIDTH-1:0]    cnt_reg;
   logic                    pmem_resp_reg;
   logic                    mem_read_reg;
   logic                    mem_write_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [LINE_WIDTH-1:0]   rdata_reg;
   logic [LINE_WIDTH-1:0]   line_merged;
   logic                    beat_ack;
   logic                    last_beat;
   logic                    unused_offset_bits;

   // Byte-offset bits of the line address carry no information here
   assign unused_offset_bits = ^pmem_address[OFFSET_BITS-1:0];

   assign beat_ack  = ((state_reg == RD_BURST) || (state_reg == WR_BURST)) && mem_resp;
   assign last_beat = (cnt_reg == CNT_WIDTH'(BEATS - 1));

   line_beat_buffer #(
      .LINE_WIDTH (LINE_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .BEATS      (BEATS),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .line_load   (state_reg == IDLE),
      .line_in     (pmem_wdata),
      .beat_load   (beat_ack && (state_reg == RD_BURST)),
      .beat_sel    (cnt_reg),
      .beat_in     (mem_rdata),
      .beat_out    (mem_wdata),
      .line_merged (line_merged)
   );

   // Transfer sequencer: capture in IDLE, count acked beats, pulse pmem_resp
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         pmem_resp_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
         addr_reg      <= '0;
         rdata_reg     <= '0;
      end else begin
         pmem_resp_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               addr_reg <= {pmem_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
               if (pmem_write) begin
                  state_reg     <= WR_BURST;
                  mem_write_reg <= 1'b1;
               end else if (pmem_read) begin
                  state_reg    <= RD_BURST;
                  mem_read_reg <= 1'b1;
               end
            end
            RD_BURST, WR_BURST: begin
               if (mem_resp) begin
                  if (last_beat) begin
                     state_reg     <= RESP;
                     cnt_reg       <= '0;
                     mem_read_reg  <= 1'b0;
                     mem_write_reg <= 1'b0;
                     pmem_resp_reg <= 1'b1;
                     if (state_reg == RD_BURST) begin
                        rdata_reg <= line_merged;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                  end
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign pmem_resp   = pmem_resp_reg;
   assign pmem_rdata  = rdata_reg;
   assign mem_read    = mem_read_reg;
   assign mem_write   = mem_write_reg;
   assign mem_address = addr_reg;

`ifdef PMEM_BURST_ADAPTER_PERF_EN
   logic [31:0] perf_reads_reg;
   logic [31:0] perf_writes_reg;

   // Completed-transfer counters, bumped on the edge that enters RESP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_reads_reg  <= '0;
         perf_writes_reg <= '0;
      end else if (beat_ack && last_beat) begin
         if (state_reg == RD_BURST) begin
            perf_reads_reg <= perf_reads_reg + 32'd1;
         end else begin
            perf_writes_reg <= perf_writes_reg + 32'd1;
         end
      end
   end

   assign perf_reads  = perf_reads_reg;
   assign perf_writes = perf_writes_reg;
`endif

endmodule
